// File: rtl/serial_gather_pkg.sv
// Shared definitions for the serial gather block and other shift-in cells.
package serial_gather_pkg;

  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 16;

  // Bits needed to count 0..value-1 (value >= 2).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/serial_gather_if.sv
// Serial-in / word-out bus between a shift-in gatherer and its consumer.
interface serial_gather_if #(
  parameter int unsigned WIDTH = 4
);

  logic             SD;
  logic             SHIFT;
  logic             nSYNC;
  logic             CLR_OVR;
  logic [WIDTH-1:0] DATA;
  logic             VALID;
  logic             READY;
  logic             OVERRUN;
  logic             BUSY;

  modport master (
    input  SD, SHIFT, nSYNC, CLR_OVR, READY,
    output DATA, VALID, OVERRUN, BUSY
  );

  modport slave (
    output SD, SHIFT, nSYNC, CLR_OVR, READY,
    input  DATA, VALID, OVERRUN, BUSY
  );

endinterface

// File: rtl/serial_gather_hold.sv
// Holding register with valid/ready output and sticky overrun flag.
module serial_gather_hold #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CK,
  input  logic             nRESET,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             ready_i,
  input  logic             clr_ovr_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             free_c;

  // The handshake is resolved first, so a word can load on the edge the old one leaves.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    free_c    = !valid_q || ready_i;

    if (clr_ovr_i) overrun_d = 1'b0;

    if (load_i) begin
      if (free_c) begin
        data_d  = word_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CK) begin
    if (!nRESET) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_gather.sv
// Serial-in, parallel-out word gatherer: MSB-first bits into a handshaked holding register.
module serial_gather
  import serial_gather_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic            CK,
  input  logic            nRESET,
  serial_gather_if.master bus
);

  localparam int unsigned CNT_W    = clog2(WIDTH);
  localparam int unsigned CNT_LAST = WIDTH - 1;
  localparam int unsigned SR_W     = WIDTH - 1;

  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_c;
  logic [WIDTH-1:0] word_c;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             overrun;

  // Bit sampling and word alignment; truncating {sr, SD} drops the oldest bit.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    load_c = 1'b0;
    word_c = {sr_q, bus.SD};

    if (bus.SHIFT && bus.nSYNC) begin
      if (cnt_q == CNT_W'(CNT_LAST)) begin
        load_c = 1'b1;
        cnt_d  = '0;
        sr_d   = '0;
      end else begin
        sr_d  = SR_W'({sr_q, bus.SD});
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (bus.SHIFT) begin
      sr_d  = SR_W'(bus.SD);
      cnt_d = CNT_W'(1);
    end else if (!bus.nSYNC) begin
      sr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge CK) begin
    if (!nRESET) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  serial_gather_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .CK        (CK),
    .nRESET    (nRESET),
    .load_i    (load_c),
    .word_i    (word_c),
    .ready_i   (bus.READY),
    .clr_ovr_i (bus.CLR_OVR),
    .data_o    (data),
    .valid_o   (valid),
    .overrun_o (overrun)
  );

  assign bus.DATA    = data;
  assign bus.VALID   = valid;
  assign bus.OVERRUN = overrun;
  assign bus.BUSY    = (cnt_q != '0);

endmodule
